// File: rtl/memory_access_if.sv
// Handshake and data-bus bundle for the memory-access pipeline stage.
// The slave modport is the stage itself. The master modport is the surrounding pipeline and bus.
interface memory_access_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] r0data_i;
  logic [31:0] r1data_i;
  logic [31:0] result_i;

  logic        valid_ro;
  logic        ready_i;
  logic [31:0] pc_ro;
  logic [31:0] inst_ro;
  logic [31:0] result_ro;
  logic        misalign_ro;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport slave (
    input  valid_i, pc_i, inst_i, r0data_i, r1data_i, result_i,
    input  ready_i, dmem_ack_i, dmem_rdata_i,
    output ready_o, valid_ro, pc_ro, inst_ro, result_ro, misalign_ro,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o
  );

  modport master (
    output valid_i, pc_i, inst_i, r0data_i, r1data_i, result_i,
    output ready_i, dmem_ack_i, dmem_rdata_i,
    input  ready_o, valid_ro, pc_ro, inst_ro, result_ro, misalign_ro,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage. It passes ALU results through, flags bad or misaligned accesses,
// and performs one load or store at a time on a single-cycle-ack data bus.
module memory_access (
  input  logic           clk,
  input  logic           rst,
  memory_access_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      r_state;
  logic        r_valid, r_misalign, r_req, r_we, r_is_load;
  logic [31:0] r_pc, r_inst, r_result, r_addr, r_wdata, r_eff_addr;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;

  logic        w_ready, w_accept, w_is_load, w_is_store, w_bad_f3, w_misalign;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm, w_addr, w_wdata, w_rshift, w_load_data;
  logic [3:0]  w_wstrb;

  assign w_ready    = (r_state == S_IDLE) & (~r_valid | bus.ready_i);
  assign w_accept   = bus.valid_i & w_ready;
  assign w_funct3   = bus.inst_i[14:12];
  assign w_is_load  = (bus.inst_i[6:0] == OP_LOAD);
  assign w_is_store = (bus.inst_i[6:0] == OP_STORE);
  assign w_imm      = w_is_store ? {{20{bus.inst_i[31]}}, bus.inst_i[31:25], bus.inst_i[11:7]}
                                 : {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
  assign w_addr     = bus.r0data_i + w_imm;
  assign w_rshift   = bus.dmem_rdata_i >> {r_eff_addr[1:0], 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_bad_f3    = 1'b0;
    w_misalign  = 1'b0;
    w_wstrb     = 4'b1111;
    w_wdata     = bus.r1data_i;
    w_load_data = w_rshift;
    if (w_is_load)
      w_bad_f3 = (w_funct3 == 3'd3) | (w_funct3 == 3'd6) | (w_funct3 == 3'd7);
    else if (w_is_store)
      w_bad_f3 = (w_funct3 >= 3'd3);
    case (w_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << w_addr[1:0];
        w_wdata = {4{bus.r1data_i[7:0]}};
      end
      2'b01: begin
        w_misalign = w_addr[0];
        w_wstrb    = 4'b0011 << w_addr[1:0];
        w_wdata    = {2{bus.r1data_i[15:0]}};
      end
      2'b10:   w_misalign = (w_addr[1:0] != 2'b00);
      default: ;
    endcase
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'd1:    w_load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'd4:    w_load_data = {24'd0, w_rshift[7:0]};
      3'd5:    w_load_data = {16'd0, w_rshift[15:0]};
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_wstrb    <= 4'b0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_result   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_eff_addr <= '0;
      r_funct3   <= '0;
      r_is_load  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc       <= bus.pc_i;
            r_inst     <= bus.inst_i;
            r_misalign <= 1'b0;
            if (!(w_is_load | w_is_store)) begin
              r_valid  <= 1'b1;
              r_result <= bus.result_i;
            end else if (w_bad_f3) begin
              r_valid  <= 1'b1;
              r_result <= 32'hFFFF_FFFF;
            end else if (w_misalign) begin
              r_valid    <= 1'b1;
              r_misalign <= 1'b1;
              r_result   <= w_addr;
            end else begin
              r_state    <= S_WAIT;
              r_valid    <= 1'b0;
              r_req      <= 1'b1;
              r_we       <= w_is_store;
              r_addr     <= {w_addr[31:2], 2'b00};
              r_wdata    <= w_wdata;
              r_wstrb    <= w_is_store ? w_wstrb : 4'b0000;
              r_eff_addr <= w_addr;
              r_funct3   <= w_funct3;
              r_is_load  <= w_is_load;
            end
          end else if (r_valid & bus.ready_i) begin
            r_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          // The bus signals are held unchanged until the single-cycle ack arrives.
          if (bus.dmem_ack_i) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_valid    <= 1'b1;
            r_misalign <= 1'b0;
            r_result   <= r_is_load ? w_load_data : r_eff_addr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.valid_ro     = r_valid;
  assign bus.pc_ro        = r_pc;
  assign bus.inst_ro      = r_inst;
  assign bus.result_ro    = r_result;
  assign bus.misalign_ro  = r_misalign;
  assign bus.dmem_req_o   = r_req;
  assign bus.dmem_we_o    = r_we;
  assign bus.dmem_addr_o  = r_addr;
  assign bus.dmem_wdata_o = r_wdata;
  assign bus.dmem_wstrb_o = r_wstrb;
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a transaction-level reference model, a per-cycle compare,
// directed scenarios with hand-computed values, and a randomized phase with a randomly acking bus.
module tb_memory_access;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_access_if bus ();
  memory_access dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy, m_valid, m_mis, m_req, m_we, m_acc, p_load;
  logic [31:0] m_result, m_pc, m_inst, m_addr, m_wdata, p_ea;
  logic [3:0]  m_wstrb;
  logic [2:0]  p_f3;

  function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [31:0] ea,
                                             input logic [2:0] f3);
    logic [31:0] raw, b, h;
    raw = rdata >> (8 * (ea % 4));
    b   = raw % 256;
    h   = raw % 65536;
    case (f3)
      3'd0:    return (b >= 128)   ? b - 256   : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic model_accept();
    logic [2:0]  f3;
    logic [11:0] imm12;
    logic [31:0] ea, r1;
    int          size;
    bit          ld, st, bad;
    ld    = (bus.inst_i[6:0] == 7'h03);
    st    = (bus.inst_i[6:0] == 7'h23);
    f3    = bus.inst_i[14:12];
    imm12 = st ? {bus.inst_i[31:25], bus.inst_i[11:7]} : bus.inst_i[31:20];
    ea    = bus.r0data_i + 32'($signed(imm12));
    r1    = bus.r1data_i;
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    bad   = ld ? (f3 == 3 || f3 >= 6) : (f3 >= 3);
    m_pc   = bus.pc_i;
    m_inst = bus.inst_i;
    m_mis  = 1'b0;
    if (!ld && !st) begin
      m_valid = 1'b1; m_result = bus.result_i;
    end else if (bad) begin
      m_valid = 1'b1; m_result = 32'hFFFF_FFFF;
    end else if (ea % size != 0) begin
      m_valid = 1'b1; m_mis = 1'b1; m_result = ea;
    end else begin
      m_busy  = 1'b1; m_req = 1'b1; m_valid = 1'b0; m_we = st;
      m_addr  = ea - (ea % 4);
      m_wstrb = st ? 4'(((1 << size) - 1) << (ea % 4)) : 4'd0;
      m_wdata = (size == 1) ? (r1 % 256) * 32'h0101_0101 :
                (size == 2) ? (r1 % 65536) * 32'h0001_0001 : r1;
      p_load  = ld; p_ea = ea; p_f3 = f3;
    end
  endtask

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_mis = 0; m_req = 0; m_we = 0; m_wstrb = 0;
      m_result = 0; m_pc = 0; m_inst = 0; m_addr = 0; m_wdata = 0;
    end else if (m_busy) begin
      if (bus.dmem_ack_i) begin
        m_busy = 0; m_req = 0; m_valid = 1; m_mis = 0;
        m_result = p_load ? load_value(bus.dmem_rdata_i, p_ea, p_f3) : p_ea;
      end
    end else if (bus.valid_i && (!m_valid || bus.ready_i)) begin
      m_acc = 1'b1;
      model_accept();
    end else if (m_valid && bus.ready_i) begin
      m_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready_o", bus.ready_o, !m_busy && (!m_valid || bus.ready_i));
      check("valid_ro", bus.valid_ro, m_valid);
      check("dmem_req_o", bus.dmem_req_o, m_req);
      if (m_valid) begin
        check("result_ro", bus.result_ro, m_result);
        check("pc_ro", bus.pc_ro, m_pc);
        check("inst_ro", bus.inst_ro, m_inst);
        check("misalign_ro", bus.misalign_ro, m_mis);
      end
      if (m_req) begin
        check("dmem_we_o", bus.dmem_we_o, m_we);
        check("dmem_addr_o", bus.dmem_addr_o, m_addr);
        check("dmem_wstrb_o", bus.dmem_wstrb_o, m_wstrb);
        if (m_we) check("dmem_wdata_o", bus.dmem_wdata_o, m_wdata);
      end
    end
  end

  // ---------------- bus responder ----------------
  // ack_mode: 0 random delay plus stray acks, 1 fixed delay, 2 never ack, 3 ack held high
  int          ack_mode = 1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;

  always @(posedge clk) begin
    #1;
    bus.dmem_ack_i = 1'b0;
    if (ack_mode == 3) begin
      bus.dmem_ack_i   = 1'b1;
      bus.dmem_rdata_i = $urandom;
    end else if (bus.dmem_req_o === 1'b1 && ack_mode != 2) begin
      if (wait_cnt >= ack_delay) begin
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = use_fixed ? fixed_rdata : $urandom;
        wait_cnt = 0;
        if (ack_mode == 0) ack_delay = $urandom % 4;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (ack_mode == 0 && $urandom % 8 == 0) begin
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = $urandom;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction
  function automatic logic [31:0] mk_st(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] mk_alu(input logic [11:0] imm);
    return {imm, 5'd1, 3'd0, 5'd2, 7'b0010011};
  endfunction

  task automatic set_item(input logic [31:0] inst, pc, r0, r1, res);
    bus.valid_i  = 1'b1;
    bus.inst_i   = inst;
    bus.pc_i     = pc;
    bus.r0data_i = r0;
    bus.r1data_i = r1;
    bus.result_i = res;
  endtask

  // Present one item and return just after the edge that accepted it.
  task automatic send(input logic [31:0] inst, pc, r0, r1, res, output int lat);
    set_item(inst, pc, r0, r1, res);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m_acc && lat < 50);
    check("send_accepted", 32'(m_acc), 32'd1);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.valid_ro !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid_ro", 32'(bus.valid_ro), 32'd1);
  endtask

  task automatic rand_item();
    logic [2:0]  f3;
    logic [11:0] imm;
    int          kind;
    f3   = 3'($urandom % 8);
    imm  = 12'($urandom % 4096);
    kind = $urandom % 4;
    set_item(kind == 0 ? mk_ld(f3, imm) : kind == 1 ? mk_st(f3, imm) : mk_alu(imm),
             $urandom, $urandom, $urandom, $urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bus.valid_i = 0; bus.ready_i = 1; bus.pc_i = 0; bus.inst_i = 0;
    bus.r0data_i = 0; bus.r1data_i = 0; bus.result_i = 0;
    bus.dmem_ack_i = 0; bus.dmem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_valid_ro", 32'(bus.valid_ro), 32'd0);
    check("rst_req", 32'(bus.dmem_req_o), 32'd0);
    check("rst_result", bus.result_ro, 32'd0);
    check("rst_ready_o", 32'(bus.ready_o), 32'd1);

    // ADDI pass-through and back-to-back throughput
    send(mk_alu(12'd16), 32'h100, 32'h0, 32'h0, 32'h10, lat);
    check("addi_valid", 32'(bus.valid_ro), 32'd1);
    check("addi_result", bus.result_ro, 32'h10);
    check("addi_no_req", 32'(bus.dmem_req_o), 32'd0);
    check("model_addi_result", m_result, 32'h10);
    send(mk_alu(12'd17), 32'h104, 32'h0, 32'h0, 32'h11, lat);
    check("b2b_latency_1", 32'(lat), 32'd1);
    send(mk_alu(12'd18), 32'h108, 32'h0, 32'h0, 32'h12, lat);
    check("b2b_latency_2", 32'(lat), 32'd1);
    check("b2b_result", bus.result_ro, 32'h12);
    @(posedge clk); #1;
    check("valid_clears", 32'(bus.valid_ro), 32'd0);

    // LB from 0x1003, ack delayed
    ack_mode = 1; ack_delay = 3; use_fixed = 1; fixed_rdata = 32'h80FF_0000;
    send(mk_ld(3'd0, 12'd0), 32'h200, 32'h1003, 32'h0, 32'h0, lat);
    check("lb_req", 32'(bus.dmem_req_o), 32'd1);
    check("lb_addr", bus.dmem_addr_o, 32'h1000);
    check("lb_we", 32'(bus.dmem_we_o), 32'd0);
    check("lb_wstrb", 32'(bus.dmem_wstrb_o), 32'd0);
    check("lb_ready_wait", 32'(bus.ready_o), 32'd0);
    wait_valid();
    check("lb_result", bus.result_ro, 32'hFFFF_FF80);
    check("model_lb_result", m_result, 32'hFFFF_FF80);
    check("lb_req_done", 32'(bus.dmem_req_o), 32'd0);

    // SH to 0x2002
    ack_delay = 1;
    send(mk_st(3'd1, 12'd0), 32'h300, 32'h2002, 32'h0000_ABCD, 32'h0, lat);
    check("sh_wstrb", 32'(bus.dmem_wstrb_o), 32'hC);
    check("sh_wdata", bus.dmem_wdata_o, 32'hABCD_ABCD);
    check("sh_we", 32'(bus.dmem_we_o), 32'd1);
    check("sh_addr", bus.dmem_addr_o, 32'h2000);
    wait_valid();
    check("sh_result", bus.result_ro, 32'h2002);

    // Misaligned LW from 0x3001
    send(mk_ld(3'd2, 12'd0), 32'h400, 32'h3001, 32'h0, 32'h0, lat);
    check("lw_mis_flag", 32'(bus.misalign_ro), 32'd1);
    check("lw_mis_result", bus.result_ro, 32'h3001);
    check("lw_mis_no_req", 32'(bus.dmem_req_o), 32'd0);
    @(posedge clk); #1;
    check("lw_mis_no_req_later", 32'(bus.dmem_req_o), 32'd0);

    // Downstream stall for four cycles, then release with the next item already waiting
    bus.ready_i = 1'b0;
    send(mk_alu(12'd1), 32'h500, 32'h0, 32'h0, 32'hAAAA, lat);
    set_item(mk_alu(12'd2), 32'h504, 32'h0, 32'h0, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(bus.valid_ro), 32'd1);
      check("stall_result", bus.result_ro, 32'hAAAA);
      check("stall_ready_o", 32'(bus.ready_o), 32'd0);
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b1;
    #1;
    check("release_ready_o", 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;
    check("release_accept", 32'(m_acc), 32'd1);
    check("release_result", bus.result_ro, 32'hBBBB);
    bus.valid_i = 1'b0;

    // Reset during WAIT, followed by stray acks
    ack_mode = 2;
    send(mk_ld(3'd2, 12'd0), 32'h600, 32'h4000, 32'h0, 32'h0, lat);
    check("wait_req", 32'(bus.dmem_req_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_mode = 3;
    check("wrst_valid", 32'(bus.valid_ro), 32'd0);
    check("wrst_req", 32'(bus.dmem_req_o), 32'd0);
    check("wrst_we", 32'(bus.dmem_we_o), 32'd0);
    check("wrst_wstrb", 32'(bus.dmem_wstrb_o), 32'd0);
    check("wrst_addr", bus.dmem_addr_o, 32'd0);
    check("wrst_wdata", bus.dmem_wdata_o, 32'd0);
    check("wrst_pc", bus.pc_ro, 32'd0);
    check("wrst_inst", bus.inst_ro, 32'd0);
    check("wrst_result", bus.result_ro, 32'd0);
    check("wrst_misalign", 32'(bus.misalign_ro), 32'd0);
    check("wrst_ready_o", 32'(bus.ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("stray_ack_valid", 32'(bus.valid_ro), 32'd0);
    check("stray_ack_req", 32'(bus.dmem_req_o), 32'd0);

    // Randomized traffic against the model
    ack_mode = 0; use_fixed = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst = ($urandom % 200 == 0);
      bus.ready_i = ($urandom % 4 != 0);
      if (!bus.valid_i || m_acc) begin
        if ($urandom % 10 < 7) rand_item();
        else bus.valid_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1; ack_mode = 1; ack_delay = 0;
    repeat (10) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
